// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame indices and default timing.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        DATA,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam int unsigned PS2_DATA_BITS   = 8;
    localparam int unsigned PS2_PARITY_FALL = 9;
    localparam int unsigned PS2_STOP_FALL   = 10;

    // 100 us request and 15 ms ACK window at a 50 MHz system clock
    localparam int unsigned PS2_INHIBIT_CYCLES_DEF = 5000;
    localparam int unsigned PS2_TIMEOUT_CYCLES_DEF = 750000;

    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the MiniAlu side and the PS/2 host transmitter.
interface ps2_host_tx_if;
    import ps2_pkg::*;

    logic [PS2_DATA_BITS-1:0] data;
    logic                     send;
    logic                     busy;
    logic                     done;
    logic                     error;

    modport master (output data, output send, input busy, input done, input error);
    modport slave  (input data, input send, output busy, output done, output error);

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer with falling-edge detect for one PS/2 line.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic fall_c
);

    logic meta;
    logic prev;

    // Reset to the idle-high bus level so release never looks like a fall
    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 1'b1;
            level <= 1'b1;
            prev  <= 1'b1;
        end else begin
            meta  <= line;
            level <= meta;
            prev  <= level;
        end
    end

    assign fall_c = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter; outputs are open-drain "drive low" enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           rst,
    ps2_host_tx_if.slave   host,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    output logic           ps2_clk_low,
    output logic           ps2_data_low
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    ps2_state_e               state;
    logic [PS2_DATA_BITS-1:0] data_q;
    logic                     parity_q;
    logic [CNT_W-1:0]         cnt;
    logic [3:0]               bit_cnt;
    logic                     busy;
    logic                     done;
    logic                     error;

    logic clk_sync;
    logic clk_fall_c;
    logic data_sync;
    logic unused_data_fall;
    logic timeout_c;

    ps2_line_sync u_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .line   (ps2_clk),
        .level  (clk_sync),
        .fall_c (clk_fall_c)
    );

    ps2_line_sync u_data_sync (
        .clk    (clk),
        .rst    (rst),
        .line   (ps2_data),
        .level  (data_sync),
        .fall_c (unused_data_fall)
    );

    assign timeout_c = (state == DATA || state == ACK || state == WAIT_IDLE) &&
                       (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Single-process FSM; the one counter times both the request and the ACK window
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            data_q       <= '0;
            parity_q     <= 1'b0;
            cnt          <= '0;
            bit_cnt      <= '0;
            ps2_clk_low  <= 1'b0;
            ps2_data_low <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (timeout_c) begin
                ps2_clk_low  <= 1'b0;
                ps2_data_low <= 1'b0;
                error        <= 1'b1;
                busy         <= 1'b0;
                state        <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        ps2_clk_low  <= 1'b0;
                        ps2_data_low <= 1'b0;
                        // A request coinciding with the completion pulse is dropped
                        if (host.send && !done && !error) begin
                            data_q      <= host.data;
                            parity_q    <= odd_parity(host.data);
                            busy        <= 1'b1;
                            ps2_clk_low <= 1'b1;
                            cnt         <= '0;
                            state       <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                            ps2_data_low <= 1'b1;
                            state        <= START;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    START: begin
                        ps2_clk_low <= 1'b0;
                        cnt         <= '0;
                        bit_cnt     <= '0;
                        state       <= DATA;
                    end
                    DATA: begin
                        cnt <= cnt + CNT_W'(1);
                        if (clk_fall_c) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt < 4'(PS2_DATA_BITS)) begin
                                ps2_data_low <= ~data_q[bit_cnt[2:0]];
                            end else if (bit_cnt == 4'(PS2_PARITY_FALL - 1)) begin
                                ps2_data_low <= ~parity_q;
                            end else if (bit_cnt == 4'(PS2_STOP_FALL - 1)) begin
                                ps2_data_low <= 1'b0;
                                state        <= ACK;
                            end
                        end
                    end
                    ACK: begin
                        cnt <= cnt + CNT_W'(1);
                        if (clk_fall_c) begin
                            if (!data_sync) begin
                                state <= WAIT_IDLE;
                            end else begin
                                error <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        cnt <= cnt + CNT_W'(1);
                        if (clk_sync && data_sync) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        ps2_clk_low  <= 1'b0;
                        ps2_data_low <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                endcase
            end
        end
    end

    assign host.busy  = busy;
    assign host.done  = done;
    assign host.error = error;

endmodule
